cdc_fifo_rd_stream_packer: RTL
==============================

// Module: cdc_fifo_rd_stream_packer
// PURPOSE
//  Read-domain consumer of the async CDC FIFO: pops DATA_WIDTH words, packs PACK consecutive words per beat,
//  presents beats on a valid/ready stream with periodic tlast. Sole driver of rd_en; never reads an empty FIFO.
//  Sits between the CDC FIFO read port and the downstream AXI-Stream fabric in the rd_clk domain.
// PARAMETERS
//  DATA_WIDTH  4   width of one FIFO word
//  PACK        4   FIFO words per output beat (>=1); m_tdata width = DATA_WIDTH*PACK
//  BURST_LEN   4   output beats per packet; m_tlast on last beat (>=1)
// PORTS
//  rd_clk          in   1                 sole clock
//  rd_rst_n_async  in   1                 asynchronous active-low reset
//  rd_empty        in   1                 FIFO empty flag (rd_clk domain)
//  rd_data         in   DATA_WIDTH        FIFO read data, valid the cycle after rd_en
//  rd_en           out  1                 FIFO pop request
//  m_tvalid        out  1                 output beat valid
//  m_tready        in   1                 downstream accept
//  m_tdata         out  DATA_WIDTH*PACK   packed beat, first-read word in LSBs
//  m_tlast         out  1                 last beat of BURST_LEN-beat packet
//  q_level         out  2                 output queue occupancy 0..3
// BEHAVIOUR
//  Interface: one clock rd_clk; reset rd_rst_n_async asynchronous, active-low, deassertion sync'd upstream.
//  Reset: rd_en=0, m_tvalid=0, m_tdata=0, m_tlast=0, q_level=0, word/beat counters=0, in-flight flag=0.
//  FIFO read latency fixed 1: rd_en in cycle N -> rd_data sampled at end of cycle N+1 (inflight flag).
//  rd_en = !rd_empty && (q_level + inflight_completes + this_read_completes) <= 3; m_tready excluded,
//   no comb path m_tready->rd_en. "completes" = that read carries word index PACK-1.
//  Accumulator: word_idx 0..PACK-1; captured word goes to slice word_idx; word_idx wraps to 0 after PACK-1.
//  On capture of word PACK-1: beat = {rd_data, acc[PACK-2:0]} pushed to queue same edge; m_tvalid next cycle.
//   Min latency rd_en(last word) cycle N -> m_tvalid cycle N+2.
//  Output queue: 3-entry FIFO, head drives m_tdata/m_tlast; pop on m_tvalid&&m_tready; push+pop same cycle
//   allowed at any level incl. full (level unchanged). Overflow impossible by rd_en rule.
//  AXI rules: m_tdata/m_tlast stable while m_tvalid&&!m_tready; m_tvalid never drops without handshake.
//  tlast: beat_cnt 0..BURST_LEN-1 increments on each push; pushed beat tagged last when beat_cnt==BURST_LEN-1,
//   then wraps to 0. BURST_LEN=1 -> every beat last.
//  Full throughput with m_tready=1: one beat per PACK cycles sustained once FIFO non-empty.
//  rd_empty rising while read in flight: in-flight word still captured; no further rd_en.
//  Reset mid-operation: partial accumulator, in-flight word and queued beats discarded; CDC FIFO reset
//   concurrently, so no stale-word realignment is attempted.
// STRUCTURE
//  Package cdc_harness_pkg: RD_LATENCY=1, OUTQ_DEPTH=3, function beat_width(DATA_WIDTH,PACK).
//  Sub-module cdc_stream_outq: 3-entry valid/ready queue (push, data+last, pop, level).
//  Top: accumulator, word/beat counters, in-flight tracker, rd_en credit logic.
//  Bind existing CDC FIFO SVA (no read when empty) plus local: queue never overflows, AXI stability.
// TESTING (DATA_WIDTH=4, PACK=4, BURST_LEN=4)
//  FIFO loaded 0x1,0x2,0x3,0x4, m_tready=1 -> one beat m_tdata=16'h4321, m_tlast=0, m_tvalid 2 cycles after 4th rd_en.
//  64 words streamed, m_tready=1 -> 16 beats in order, one per 4 cycles steady, m_tlast on beats 3,7,11,15; rd_en never with rd_empty=1.
//  m_tready=0 for 30 cycles with FIFO full -> q_level saturates at 3, rd_en stays 0, head beat stable;
//   release -> all beats delivered, no loss/duplication.
//  rd_empty toggling every cycle, random m_tready -> scoreboard word order exact, tlast cadence intact.
//  Reset asserted after 2 words of a beat + 1 queued -> all outputs 0 asynchronously; after release,
//   words 0xA,0xB,0xC,0xD -> 16'hDCBA with beat_cnt restarted (tlast on 4th post-reset beat).
//  PACK=1, BURST_LEN=1 build -> each word is a beat with m_tlast=1, one beat per cycle sustained.

Source files
------------

// File: rtl/cdc_harness_pkg.sv
// Shared constants and helpers for the CDC FIFO read-side stream packer.
// Read latency, output queue depth and beat width helper.
package cdc_harness_pkg;

    localparam int RD_LATENCY = 1;
    localparam int OUTQ_DEPTH = 3;

    function automatic int beat_width(input int dw, input int pk);
        return dw * pk;
    endfunction

endpackage

// File: rtl/cdc_stream_outq.sv
// Three-entry valid/ready output queue for packed beats.
// Head entry drives the stream; push and pop may coincide at any level.
module cdc_stream_outq
    import cdc_harness_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         push_last_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         last_o,
    output logic [1:0]   level_o
);

    logic [W:0] mem_q [OUTQ_DEPTH];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [1:0] level_q;
    logic       pop_w;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(OUTQ_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Head view and effective pop (only when something is queued)
    always_comb begin
        valid_o          = (level_q != 2'd0);
        {last_o, data_o} = mem_q[rd_ptr_q];
        level_o          = level_q;
        pop_w            = pop_i && valid_o;
    end

    // Ring storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUTQ_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            level_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_w) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            level_q <= level_q + 2'(push_i) - 2'(pop_w);
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_w && (level_q == 2'(OUTQ_DEPTH)))
    );

endmodule

// File: rtl/cdc_fifo_rd_stream_packer.sv
// Read-domain consumer of the CDC FIFO: packs PACK words per beat
// and streams beats with periodic tlast, never popping an empty FIFO.
module cdc_fifo_rd_stream_packer
    import cdc_harness_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int PACK       = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                                       rd_clk,
    input  logic                                       rd_rst_n_async,
    input  logic                                       rd_empty,
    input  logic [DATA_WIDTH-1:0]                      rd_data,
    output logic                                       rd_en,
    output logic                                       m_tvalid,
    input  logic                                       m_tready,
    output logic [beat_width(DATA_WIDTH, PACK)-1:0]    m_tdata,
    output logic                                       m_tlast,
    output logic [1:0]                                 q_level
);

    localparam int BW = beat_width(DATA_WIDTH, PACK);
    localparam int IW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [IW-1:0] rd_idx_q;
    logic [IW-1:0] word_idx_q;
    logic [CW-1:0] beat_cnt_q;
    logic          inflight_q;
    logic          infl_last_q;
    logic [BW-1:0] acc_q;
    logic [BW-1:0] beat_d;
    logic          this_done_d;
    logic [2:0]    need_d;
    logic          push_d;
    logic          last_d;

    // Read credit: a read is issued only if every beat it or the
    // in-flight read completes still fits in the output queue
    always_comb begin
        this_done_d = (rd_idx_q == IW'(PACK - 1));
        need_d      = {1'b0, q_level} + {2'b0, infl_last_q}
                    + {2'b0, this_done_d};
        rd_en       = rd_rst_n_async && !rd_empty
                    && (need_d <= 3'(OUTQ_DEPTH));
    end

    // Beat assembly: the captured word closes the beat in the top slice
    always_comb begin
        push_d = inflight_q && (word_idx_q == IW'(PACK - 1));
        last_d = (beat_cnt_q == CW'(BURST_LEN - 1));
        beat_d = acc_q;
        beat_d[(PACK-1)*DATA_WIDTH +: DATA_WIDTH] = rd_data;
    end

    // Read tracking, word capture and packet beat counting
    always_ff @(posedge rd_clk or negedge rd_rst_n_async) begin
        if (!rd_rst_n_async) begin
            rd_idx_q    <= '0;
            word_idx_q  <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            acc_q       <= '0;
        end else begin
            inflight_q  <= rd_en;
            infl_last_q <= rd_en && this_done_d;
            if (rd_en) begin
                rd_idx_q <= this_done_d ? '0 : rd_idx_q + IW'(1);
            end
            if (inflight_q) begin
                for (int i = 0; i < PACK; i++) begin
                    if (word_idx_q == IW'(i)) begin
                        acc_q[i*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
                    end
                end
                word_idx_q <= push_d ? '0 : word_idx_q + IW'(1);
            end
            if (push_d) begin
                beat_cnt_q <= last_d ? '0 : beat_cnt_q + CW'(1);
            end
        end
    end

    cdc_stream_outq #(
        .W (BW)
    ) u_outq (
        .clk         (rd_clk),
        .rst_n       (rd_rst_n_async),
        .push_i      (push_d),
        .push_data_i (beat_d),
        .push_last_i (last_d),
        .pop_i       (m_tready),
        .valid_o     (m_tvalid),
        .data_o      (m_tdata),
        .last_o      (m_tlast),
        .level_o     (q_level)
    );

    a_no_read_empty: assert property (
        @(posedge rd_clk) disable iff (!rd_rst_n_async)
        rd_en |-> !rd_empty
    );

    a_rd_latency: assert property (
        @(posedge rd_clk) disable iff (!rd_rst_n_async)
        rd_en |-> ##RD_LATENCY inflight_q
    );

    a_axi_stable: assert property (
        @(posedge rd_clk) disable iff (!rd_rst_n_async)
        (m_tvalid && !m_tready) |=>
            (m_tvalid && $stable(m_tdata) && $stable(m_tlast))
    );

endmodule
